// File: rtl/trace_event_encoder.sv
// trace_event_encoder: timestamps pattern-matcher hits into 18-bit FIFO words.
// Define TRACE_LONG_TIME_EN for full-width TIME words ahead of long-gap MATCHes.
module trace_event_encoder #(
    parameter int pSHORTTIME_LEN = 8,
    parameter int pFULLTIME_LEN  = 16
) (
    input  logic        trace_clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [7:0]  match_hit,
    input  logic [7:0]  pattern_enable,
    input  logic [7:0]  pattern_trig_enable,
    input  logic        clear_status,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [17:0] fifo_din,
    output logic        trig_out,
    output logic        overflow_blocked,
    output logic        event_dropped
);

    localparam logic [1:0] CMD_MATCH = 2'b01;
    localparam logic [1:0] CMD_TIME  = 2'b10;
    localparam logic [pFULLTIME_LEN-1:0] ONE =
        pFULLTIME_LEN'(1);
    localparam logic [pFULLTIME_LEN-1:0] SHORT_MAX =
        pFULLTIME_LEN'((64'd1 << pSHORTTIME_LEN) - 64'd1);

`ifdef TRACE_LONG_TIME_EN
    localparam logic [pFULLTIME_LEN-1:0] CNT_MAX = '1;
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SEND_MATCH
    } state_t;
`else
    localparam logic [pFULLTIME_LEN-1:0] CNT_MAX = SHORT_MAX;
    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;
`endif

    state_t state;
    state_t state_nxt;

    logic [pFULLTIME_LEN-1:0] elapsed;
    logic [7:0]  hits;
    logic [7:0]  short_time;
    logic [2:0]  rule;
    logic [2:0]  pend_rule;
    logic [17:0] word;
    logic        hit_any;
    logic        accept;
    logic        long_gap;
    logic        drop_set;
    logic        word_due;
    logic        wr_nxt;
    logic        ovf_set;

    assign hits       = match_hit & pattern_enable;
    assign hit_any    = |hits;
    assign accept     = (state == RUN) && hit_any;
    assign short_time = 8'(elapsed);

    // Lowest enabled rule wins when several hit together.
    always_comb begin
        rule = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hits[i]) rule = 3'(i);
        end
    end

`ifdef TRACE_LONG_TIME_EN
    assign long_gap = elapsed > SHORT_MAX;
    assign drop_set = (state == SEND_MATCH) && hit_any;

    always_ff @(posedge trace_clk) begin
        if (reset) pend_rule <= 3'd0;
        else if (accept) pend_rule <= rule;
    end
`else
    assign long_gap  = 1'b0;
    assign drop_set  = 1'b0;
    assign pend_rule = 3'd0;
`endif

    always_ff @(posedge trace_clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (arm) state_nxt = RUN;
            RUN: begin
                if (!arm) state_nxt = IDLE;
`ifdef TRACE_LONG_TIME_EN
                if (accept && long_gap) state_nxt = SEND_MATCH;
`endif
            end
`ifdef TRACE_LONG_TIME_EN
            SEND_MATCH: state_nxt = arm ? RUN : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_due = 1'b0;
        word     = '0;
        unique case (state)
            RUN: begin
                if (hit_any) begin
                    word_due = 1'b1;
                    if (long_gap)
                        word = {CMD_TIME, 16'(elapsed)};
                    else
                        word = {CMD_MATCH, 5'd0, rule, short_time};
                end
            end
`ifdef TRACE_LONG_TIME_EN
            SEND_MATCH: begin
                word_due = 1'b1;
                word     = {CMD_MATCH, 5'd0, pend_rule, 8'h00};
            end
`endif
            default: ;
        endcase
    end

    // A blocked record stays blocked: the flag gates its trailing MATCH too.
    assign wr_nxt  = word_due && !overflow_blocked && !fifo_full;
    assign ovf_set = word_due && !overflow_blocked && fifo_full;

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            elapsed          <= '0;
            fifo_wr          <= 1'b0;
            fifo_din         <= '0;
            trig_out         <= 1'b0;
            overflow_blocked <= 1'b0;
            event_dropped    <= 1'b0;
        end else begin
            if ((state == IDLE && arm) || accept)
                elapsed <= ONE;
            else if (elapsed != CNT_MAX)
                elapsed <= elapsed + ONE;
            fifo_wr <= wr_nxt;
            if (wr_nxt) fifo_din <= word;
            trig_out <= accept && pattern_trig_enable[rule];
            overflow_blocked <=
                ovf_set | (overflow_blocked & ~clear_status);
            event_dropped <=
                drop_set | (event_dropped & ~clear_status);
        end
    end

endmodule

// File: tb/tb_trace_event_encoder.sv
// Scoreboard bench for trace_event_encoder: random and directed stimulus
// against an absolute-cycle reference model; TRACE_LONG_TIME_EN aware.
module tb_trace_event_encoder;

`ifdef TRACE_LONG_TIME_EN
    localparam bit LONG = 1'b1;
    localparam int TMAX = 65535;
`else
    localparam bit LONG = 1'b0;
    localparam int TMAX = 255;
`endif

    logic        trace_clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [7:0]  match_hit;
    logic [7:0]  pattern_enable;
    logic [7:0]  pattern_trig_enable;
    logic        clear_status;
    logic        fifo_full;
    logic        fifo_wr;
    logic [17:0] fifo_din;
    logic        trig_out;
    logic        overflow_blocked;
    logic        event_dropped;

    trace_event_encoder dut (
        .trace_clk          (trace_clk),
        .reset              (reset),
        .arm                (arm),
        .match_hit          (match_hit),
        .pattern_enable     (pattern_enable),
        .pattern_trig_enable(pattern_trig_enable),
        .clear_status       (clear_status),
        .fifo_full          (fifo_full),
        .fifo_wr            (fifo_wr),
        .fifo_din           (fifo_din),
        .trig_out           (trig_out),
        .overflow_blocked   (overflow_blocked),
        .event_dropped      (event_dropped)
    );

    always #5 trace_clk = ~trace_clk;

    int ecnt = 0;
    always @(posedge trace_clk) ecnt <= ecnt + 1;

    typedef struct {
        int          e;
        logic [17:0] w;
    } wr_t;

    typedef struct {
        int e;
        bit rst;
        bit trig;
        bit ovf;
        bit drop;
    } cy_t;

    wr_t wq[$];
    cy_t cq[$];

    int vectors     = 0;
    int miscompares = 0;

    // Model state: mode 0 idle, 1 running, 2 owes a MATCH word.
    int          m_mode = 0;
    int          m_ref  = 0;
    int          m_prule = 0;
    bit          m_ovf  = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_ovf_set;

    task automatic emit(input int e, input logic [17:0] w);
        if (!m_ovf) begin
            if (fifo_full) m_ovf_set = 1'b1;
            else wq.push_back('{e, w});
        end
    endtask

    task automatic model(input int e);
        cy_t        c;
        bit         drop_set;
        bit         trg;
        logic [7:0] h;
        int         rule;
        int         el;
        m_ovf_set = 1'b0;
        drop_set  = 1'b0;
        trg       = 1'b0;
        h         = match_hit & pattern_enable;
        rule      = -1;
        for (int i = 7; i >= 0; i--)
            if (h[i]) rule = i;
        c.e   = e;
        c.rst = reset;
        if (reset) begin
            m_mode = 0;
            m_ovf  = 1'b0;
            m_drop = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    if (arm) begin
                        m_mode = 1;
                        m_ref  = e;
                    end
                end
                1: begin
                    if (rule >= 0) begin
                        el = e - m_ref;
                        if (el > TMAX) el = TMAX;
                        m_ref = e;
                        trg = pattern_trig_enable[rule];
                        if (LONG && el > 255) begin
                            emit(e, {2'b10, 16'(el)});
                            m_prule = rule;
                            m_mode  = 2;
                        end else begin
                            emit(e, {2'b01, 8'(rule), 8'(el)});
                            if (!arm) m_mode = 0;
                        end
                    end else if (!arm) begin
                        m_mode = 0;
                    end
                end
                default: begin
                    if (rule >= 0) drop_set = 1'b1;
                    emit(e, {2'b01, 8'(m_prule), 8'h00});
                    m_mode = arm ? 1 : 0;
                end
            endcase
            m_ovf  = m_ovf_set | (m_ovf & ~clear_status);
            m_drop = drop_set | (m_drop & ~clear_status);
        end
        c.trig = trg;
        c.ovf  = m_ovf;
        c.drop = m_drop;
        cq.push_back(c);
    endtask

    task automatic apply(input bit r, input bit a,
                         input bit [7:0] mh, input bit [7:0] pe,
                         input bit [7:0] te, input bit clr,
                         input bit full);
        reset               = r;
        arm                 = a;
        match_hit           = mh;
        pattern_enable      = pe;
        pattern_trig_enable = te;
        clear_status        = clr;
        fifo_full           = full;
        model(ecnt + 1);
    endtask

    task automatic drive(input bit r, input bit a,
                         input bit [7:0] mh, input bit [7:0] pe,
                         input bit [7:0] te, input bit clr,
                         input bit full);
        @(negedge trace_clk);
        apply(r, a, mh, pe, te, clr, full);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1, 8'h00, 8'hFF, 8'h00, 0, 0);
    endtask

    task automatic hit(input bit [7:0] mh);
        drive(0, 1, mh, 8'hFF, 8'h00, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h",
                     nm, ecnt, act, exp);
        end
    endtask

    // Monitor: compares every modelled edge; pops FIFO words when due.
    logic [17:0] last_din = '0;
    initial begin
        cy_t c;
        forever begin
            @(posedge trace_clk);
            #1;
            if (cq.size() > 0) begin
                c = cq.pop_front();
                chk("edge_sync", c.e, ecnt);
                chk("trig_out", trig_out, c.trig);
                chk("overflow_blocked", overflow_blocked, c.ovf);
                chk("event_dropped", event_dropped, c.drop);
                if (c.rst) last_din = '0;
                if (wq.size() > 0 && wq[0].e == ecnt) begin
                    chk("fifo_wr", fifo_wr, 1'b1);
                    chk("fifo_din", fifo_din, wq[0].w);
                    last_din = wq[0].w;
                    void'(wq.pop_front());
                end else begin
                    chk("fifo_wr_idle", fifo_wr, 1'b0);
                    chk("fifo_din_hold", fifo_din, last_din);
                end
            end
        end
    end

    initial begin
        bit          a;
        bit [7:0]    pe;
        bit [7:0]    te;
        bit [7:0]    mh;
        int          hp;
        int          len;
        apply(1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        repeat (2) drive(1, 0, 8'h00, 8'h00, 8'h00, 0, 0);
        drive(0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);

        // Arm, rule 3 ten cycles later.
        drive(0, 1, 8'h00, 8'hFF, 8'h00, 0, 0);
        idle(9);
        hit(8'h08);

        // Rule 1 then rule 5, 300 cycles apart.
        idle(5);
        hit(8'h02);
        idle(299);
        hit(8'h20);
        idle(3);

        // Lowest-bit selection and trigger mask.
        drive(0, 1, 8'h0A, 8'hFF, 8'h02, 0, 0);
        idle(1);
        drive(0, 1, 8'h0A, 8'h08, 8'h02, 0, 0);
        idle(3);

        // FIFO full blocks; clear restores writes.
        drive(0, 1, 8'h01, 8'hFF, 8'h01, 0, 1);
        idle(3);
        drive(0, 1, 8'h04, 8'hFF, 8'h04, 0, 0);
        idle(2);
        drive(0, 1, 8'h00, 8'hFF, 8'h00, 1, 0);
        idle(2);
        hit(8'h10);

        // Hit right behind a long-gap event.
        idle(300);
        hit(8'h01);
        hit(8'h02);
        idle(4);
        hit(8'h04);
        drive(0, 1, 8'h00, 8'hFF, 8'h00, 1, 0);

        // Reset right behind a long-gap event.
        idle(300);
        hit(8'h01);
        drive(1, 1, 8'h00, 8'hFF, 8'h00, 0, 0);
        idle(2);
        hit(8'h40);

        // Randomised segments.
        a = 1'b1;
        for (int s = 0; s < 40; s++) begin
            pe = ($urandom_range(0, 3) == 0) ? 8'hFF
                                             : 8'($urandom);
            te = 8'($urandom);
            case ($urandom_range(0, 2))
                0: hp = 3;
                1: hp = 40;
                default: hp = 500;
            endcase
            len = (hp == 500) ? $urandom_range(300, 900)
                              : $urandom_range(20, 150);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 99) == 0) a = ~a;
                mh = ($urandom_range(1, hp) == 1) ? 8'($urandom)
                                                  : 8'h00;
                drive(($urandom_range(0, 1499) == 0), a, mh, pe, te,
                      ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 39) == 0));
            end
        end

        repeat (4) drive(0, 0, 8'h00, 8'hFF, 8'h00, 0, 0);
        @(posedge trace_clk);
        #2;
        chk("words_left", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trace_event_encoder.md
TRACE_EVENT_ENCODER -- requirements
Module: trace_event_encoder

Interface
REQ-001 SHALL have parameter pSHORTTIME_LEN, default 8, short timestamp width in MATCH words.
REQ-002 SHALL have parameter pFULLTIME_LEN, default 16, timestamp width in TIME words.
REQ-003 SHALL have port trace_clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port arm, input, 1, level; capture enabled while high.
REQ-006 SHALL have port match_hit, input, 8, per-rule hit strobes from the pattern matcher, valid for one cycle.
REQ-007 SHALL have port pattern_enable, input, 8, per-rule capture enable mask.
REQ-008 SHALL have port pattern_trig_enable, input, 8, per-rule trigger enable mask.
REQ-009 SHALL have port clear_status, input, 1, one-cycle pulse clearing sticky flags.
REQ-010 SHALL have port fifo_full, input, 1, downstream FIFO full.
REQ-011 SHALL have port fifo_wr, output, 1, FIFO write strobe.
REQ-012 SHALL have port fifo_din, output, 18, FIFO word: [17:16] command, [15:0] payload.
REQ-013 SHALL have port trig_out, output, 1, one-cycle trigger pulse.
REQ-014 SHALL have ports overflow_blocked and event_dropped, output, 1 each, sticky status flags.

Function
REQ-015 Command encoding SHALL be: MATCH = 2'b01 (payload [15:8] rule index, [7:0] short time); TIME = 2'b10 (payload [15:0] full time).
REQ-016 States SHALL be IDLE, RUN, SEND_MATCH; IDLE->RUN when arm=1; RUN->IDLE when arm=0 and no record in progress.
REQ-017 Elapsed counter SHALL load 1 on the IDLE->RUN transition cycle and on each accepted event, otherwise increment, saturating at 2^pFULLTIME_LEN-1.
REQ-018 An event SHALL be accepted in RUN when (match_hit & pattern_enable) != 0; rule index = lowest set bit.
REQ-019 Accepted event at cycle N with elapsed <= 2^pSHORTTIME_LEN-1: MATCH word {rule, elapsed} with fifo_wr=1 at cycle N+1.
REQ-020 Otherwise: TIME word {elapsed} at N+1, then MATCH word {rule, 8'h00} at N+2 via SEND_MATCH.
REQ-021 Hits arriving in SEND_MATCH SHALL be dropped, event_dropped set, and the counter SHALL NOT reload.
REQ-022 trig_out SHALL pulse at N+1 if the accepted rule's pattern_trig_enable bit is set, independent of FIFO state.
REQ-023 If fifo_full=1 in a cycle where a word would be written: no write, rest of record suppressed, overflow_blocked set.
REQ-024 While overflow_blocked=1, no FIFO writes; events are still timed, and trig_out still operates.
REQ-025 clear_status SHALL clear both sticky flags; a simultaneous set event SHALL take priority.
REQ-026 arm falling mid-record SHALL let the record complete before IDLE; hits in IDLE are ignored.
REQ-027 fifo_din SHALL hold its last value when fifo_wr=0.

Reset
REQ-028 reset SHALL force IDLE, counter 0, fifo_wr=0, fifo_din=0, trig_out=0, both flags 0.
REQ-029 reset asserted in SEND_MATCH SHALL abort the record; no MATCH word written.

Configuration
REQ-030 Macro TRACE_LONG_TIME_EN defined: TIME words per REQ-020.
REQ-031 Macro TRACE_LONG_TIME_EN undefined: counter saturates at 2^pSHORTTIME_LEN-1, no TIME words ever, SEND_MATCH state absent.

Verification
REQ-032 Arm, hit rule 3 (enabled) 10 cycles later -> single MATCH word 0x1_030A one cycle after hit.
REQ-033 Hit rule 1 then rule 5 with 300 cycles between -> second record: TIME 0x2_012C, then MATCH 0x1_0500; with macro undefined -> MATCH 0x1_05FF only.
REQ-034 match_hit=8'h0A, pattern_trig_enable=8'h02 -> MATCH rule 1, trig_out one pulse; pattern_enable=8'h08 -> rule 3, no trigger.
REQ-035 fifo_full=1 on a record -> no write, overflow_blocked=1, later events unwritten; clear_status -> next event writes normally.
REQ-036 Hit during SEND_MATCH -> dropped, event_dropped=1, next event's time measured from prior accepted event.
REQ-037 reset during SEND_MATCH -> no MATCH written, all outputs 0, state IDLE.
